i2c_slave_read_bit: RTL and testbench



---
 rtl/i2c_bit_pkg.sv | 19 +
 rtl/i2c_slave_read_bit_scl_edge.sv | 29 ++
 rtl/i2c_slave_read_bit.sv | 82 ++++++++
 tb/tb_i2c_slave_read_bit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/i2c_bit_pkg.sv
// Shared definitions for the I2C bit-level send/receive modules.
package i2c_bit_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2
    } bit_state_e;

    localparam logic [1:0] SCL_EDGE_NONE = 2'b00;
    localparam logic [1:0] SCL_EDGE_RISE = 2'b01;
    localparam logic [1:0] SCL_EDGE_FALL = 2'b10;

    // {fall, rise} classification of one SCL sample pair.
    function automatic logic [1:0] scl_edge(input logic last, input logic cur);
        return {last & ~cur, ~last & cur};
    endfunction

endpackage

// File: rtl/i2c_slave_read_bit_scl_edge.sv
// SCL edge detector: one-cycle rise/fall strobes from the previous SCL sample.
module i2c_scl_edge_detect
    import i2c_bit_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    output logic scl_rise,
    output logic scl_fall
);

    logic       scl_last_q;
    logic       scl_last_d;
    logic [1:0] edge_type;

    // Idle bus is high, so resetting to 1 avoids a false rise after reset.
    always_ff @(posedge clk) begin
        if (rst_n) scl_last_q <= 1'b1;
        else       scl_last_q <= scl_last_d;
    end

    always_comb begin
        scl_last_d = scl_i;
        edge_type  = scl_edge(scl_last_q, scl_i);
        scl_rise   = (edge_type == SCL_EDGE_RISE);
        scl_fall   = (edge_type == SCL_EDGE_FALL);
    end

endmodule

// File: rtl/i2c_slave_read_bit.sv
// Receives one I2C bit: samples SDA on SCL rise, flags SDA movement while SCL
// is high, and pulses finish on SCL fall (or on the error).
module i2c_slave_read_bit
    import i2c_bit_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bit_read_en,
    input  logic scl_i,
    input  logic sda_i,
    output logic bit_read_o,
    output logic bit_read_err,
    output logic bit_read_finish
);

    bit_state_e state_q, state_d;
    logic       bit_q, bit_d;
    logic       err_q, err_d;
    logic       fin_q, fin_d;
    logic       scl_rise, scl_fall;

    i2c_scl_edge_detect u_scl_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            bit_q   <= 1'b0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        err_d   = 1'b0;
        fin_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bit_read_en) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (!bit_read_en) begin
                    state_d = IDLE;
                end else if (scl_rise) begin
                    bit_d   = sda_i;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                // Mismatch is checked before fall so a change on the fall cycle still errors.
                if (!bit_read_en) begin
                    state_d = IDLE;
                end else if (sda_i != bit_q) begin
                    err_d   = 1'b1;
                    fin_d   = 1'b1;
                    state_d = IDLE;
                end else if (scl_fall) begin
                    fin_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bit_read_o      = bit_q;
    assign bit_read_err    = err_q;
    assign bit_read_finish = fin_q;

endmodule

// File: tb/tb_i2c_slave_read_bit.sv
// Directed bench for i2c_slave_read_bit: nominal stream, glitch, abort, reset, late enable.
module tb_i2c_slave_read_bit;

    logic clk = 1'b0;
    logic rst_n, bit_read_en, scl_i, sda_i;
    logic bit_read_o, bit_read_err, bit_read_finish;

    int n_vec = 0;
    int n_bad = 0;
    int fin_cnt = 0;
    int err_cnt = 0;

    i2c_slave_read_bit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bit_read_en     (bit_read_en),
        .scl_i           (scl_i),
        .sda_i           (sda_i),
        .bit_read_o      (bit_read_o),
        .bit_read_err    (bit_read_err),
        .bit_read_finish (bit_read_finish)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bit_read_finish === 1'b1) fin_cnt <= fin_cnt + 1;
        if (bit_read_err === 1'b1)    err_cnt <= err_cnt + 1;
    end

    task automatic step(input logic r, input logic s, input logic d, input logic e);
        rst_n = r; scl_i = s; sda_i = d; bit_read_en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] data;
        int f0, e0;
        data = 32'h1357_9BDF;

        // Reset with bus idle
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        chk("rst_bit", bit_read_o, 0);
        chk("rst_err", bit_read_err, 0);
        chk("rst_fin", bit_read_finish, 0);

        // Nominal stream, MSB first
        f0 = fin_cnt; e0 = err_cnt;
        for (int i = 31; i >= 0; i--) begin
            step(0, 0, data[i], 1);
            step(0, 0, data[i], 1);
            step(0, 1, data[i], 1);
            chk($sformatf("nom_bit%0d", i), bit_read_o, int'(data[i]));
            step(0, 1, data[i], 1);
            step(0, 0, data[i], 1);
            chk($sformatf("nom_fin%0d", i), bit_read_finish, 1);
            chk($sformatf("nom_err%0d", i), bit_read_err, 0);
            step(0, 0, (i > 0) ? data[i-1] : 1'b0, 0);
            chk($sformatf("nom_hold%0d", i), {bit_read_finish, bit_read_o}, int'(data[i]));
        end
        chk("nom_fin_count", fin_cnt - f0, 32);
        chk("nom_err_count", err_cnt - e0, 0);

        // Glitch: SDA drops one cycle into SCL high after sampling 1
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        chk("gl_bit", bit_read_o, 1);
        step(0, 1, 0, 1);
        chk("gl_err", bit_read_err, 1);
        chk("gl_fin", bit_read_finish, 1);
        chk("gl_bit_hold", bit_read_o, 1);
        step(0, 1, 0, 0);
        chk("gl_pulse_clr", {bit_read_err, bit_read_finish}, 0);
        step(0, 0, 0, 0);

        // Abort between rise and fall, then a normal transfer
        f0 = fin_cnt; e0 = err_cnt;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        chk("ab_bit", bit_read_o, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("ab_hold", bit_read_o, 0);
        chk("ab_no_pulse", fin_cnt + err_cnt - f0 - e0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        chk("ab_next_bit", bit_read_o, 1);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        chk("ab_next_fin", bit_read_finish, 1);
        step(0, 0, 1, 0);
        chk("ab_fin_count", fin_cnt - f0, 1);
        chk("ab_err_count", err_cnt - e0, 0);

        // Reset during HIGH, then a fresh 0
        f0 = fin_cnt; e0 = err_cnt;
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        chk("rs_bit_pre", bit_read_o, 1);
        step(1, 1, 1, 1);
        chk("rs_outs", {bit_read_o, bit_read_err, bit_read_finish}, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rs_no_pulse", fin_cnt + err_cnt - f0 - e0, 0);
        step(0, 1, 0, 1);
        chk("rs_bit", bit_read_o, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        chk("rs_fin", bit_read_finish, 1);
        step(0, 0, 0, 0);
        chk("rs_fin_count", fin_cnt - f0, 1);

        // Late enable while SCL already high with SDA=0
        f0 = fin_cnt; e0 = err_cnt;
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        chk("le_no_sample", bit_read_o, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        chk("le_bit", bit_read_o, 1);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        chk("le_fin", bit_read_finish, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("le_fin_count", fin_cnt - f0, 1);
        chk("le_err_count", err_cnt - e0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
